// File: rtl/rca_seq_ctrl.sv
// Sequential wide adder controller: walks WORDS 16-bit slices through an external
// ripple-carry adder, holding each slice SETTLE cycles before capturing its result.
module rca_seq_ctrl #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [16*WORDS-1:0]   a_i,
  input  logic [16*WORDS-1:0]   b_i,
  input  logic                  cin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [16*WORDS-1:0]   sum_o,
  output logic                  cout_o,
  output logic [15:0]           add_a_o,
  output logic [15:0]           add_b_o,
  output logic                  add_cin_o,
  input  logic [15:0]           add_sum_i,
  input  logic                  add_cout_i
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [16*WORDS-1:0] a_q, a_d;
  logic [16*WORDS-1:0] b_q, b_d;
  logic [16*WORDS-1:0] sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic last_cnt, last_idx;
  assign last_cnt = (cnt_q == CntW'(SETTLE - 1));
  assign last_idx = (idx_q == IdxW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          sum_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Adder outputs are only trusted on the final settle cycle of a slice.
        if (last_cnt) begin
          sum_d[16*idx_q +: 16] = add_sum_i;
          carry_d               = add_cout_i;
          cnt_d                 = '0;
          if (last_idx) begin
            cout_d  = add_cout_i;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign add_a_o     = (state_q == StRun) ? a_q[16*idx_q +: 16] : '0;
  assign add_b_o     = (state_q == StRun) ? b_q[16*idx_q +: 16] : '0;
  assign add_cin_o   = (state_q == StRun) ? carry_q : 1'b0;

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 Parameter: WORDS, default 4; number of 16-bit slices per operand.
REQ-002 Parameter: SETTLE, default 2; cycles each slice is held on the adder (must be at least 1).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  controller able to accept operands.
REQ-007 a, b  input  16*WORDS each  operands.
REQ-008 cin  input  1  carry-in of the wide addition.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  16*WORDS  registered result.
REQ-012 cout  output  1  registered final carry-out.
REQ-013 add_a, add_b  output  16 each  operand slice driven to the external 16-bit ripple-carry adder.
REQ-014 add_cin  output  1  carry driven to the external adder.
REQ-015 add_sum  input  16  sum returned from the external adder.
REQ-016 add_cout  input  1  carry-out returned from the external adder.

Function
REQ-017 The controller SHALL have three states: IDLE, RUN and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 An accept occurs when in_valid and in_ready are both 1 at an edge; it SHALL register a, b and cin, clear sum, set slice index idx=0 and counter cnt=0, and go to RUN.
REQ-019 In RUN, the controller SHALL drive add_a=a_reg[16*idx+:16], add_b=b_reg[16*idx+:16] and add_cin=carry_reg; carry_reg is cin at accept and is then updated per slice.
REQ-020 In RUN, at each edge with cnt<SETTLE-1, the controller SHALL increment cnt, with no capture.
REQ-021 In RUN, at each edge with cnt==SETTLE-1, the controller SHALL capture:
- sum[16*idx+:16] <= add_sum;
- carry_reg <= add_cout;
- cnt <= 0.
REQ-022 After a capture with idx<WORDS-1, the controller SHALL increment idx and remain in RUN.
REQ-023 After a capture with idx==WORDS-1, the controller SHALL set cout <= add_cout and go to DONE.
REQ-024 Latency: out_valid SHALL rise exactly WORDS*SETTLE cycles after the accept edge (8 cycles with the defaults).
REQ-025 In DONE, sum, cout and out_valid SHALL hold until out_valid and out_ready are both 1 at an edge; that edge SHALL return the controller to IDLE.
REQ-026 The controller SHALL NOT accept in the same cycle as an output handshake; in_valid in RUN or DONE SHALL be ignored.
REQ-027 Outside RUN, add_a, add_b and add_cin SHALL be 0.
REQ-028 The controller SHALL ignore add_sum and add_cout except at capture edges.
REQ-029 Arithmetic SHALL be unsigned modulo 2^(16*WORDS), with cout as bit 16*WORDS of a+b+cin.
REQ-030 sum SHALL be registered only (no combinational path from add_sum to sum).

Reset
REQ-031 On an edge with rst=1, the controller SHALL force the following, overriding any handshake in the same cycle:
- state to IDLE;
- in_ready=1, out_valid=0;
- sum=0, cout=0;
- idx=0, cnt=0, carry_reg=0;
- a_reg=0, b_reg=0;
- add_a, add_b and add_cin to 0.
REQ-032 A reset in RUN or DONE SHALL abort the operation with no result produced; the first accept after rst deasserts SHALL start a fresh operation.

Verification
REQ-033 Default params, a=0, b=0, cin=0 -> out_valid 8 cycles after accept, sum=0, cout=0.
REQ-034 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, and add_cin=1 observed on slices 1..3 (carry ripples across all slices).
REQ-035 a=64'h0000_0000_0000_F0F0, b=64'h0000_0000_0000_0F0F, cin=1 -> sum=64'h0000_0000_0001_0000, cout=0.
REQ-036 Hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with different operands -> sum, cout and out_valid held and in_ready=0; after out_ready=1, IDLE is reached next cycle and the second operands are accepted only then.
REQ-037 Assert rst on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0 and add_* =0; a new request then completes with the correct result after 8 cycles.
REQ-038 SETTLE=1, WORDS=2, a=32'h0001_FFFF, b=32'h0000_0001, cin=0 -> out_valid 2 cycles after accept, sum=32'h0002_0000, cout=0.
